// File: rtl/stream_utils_pkg.sv
// Shared types and constants for the stream utility blocks.
//  - pattern mode encodings and source FSM states
//  - throttle LFSR taps, zero-seed substitute and step/seed helpers
package stream_utils_pkg;

  // Data pattern selection, encoded as on mode_i.
  typedef enum logic [1:0] {
    MODE_INCR  = 2'd0,
    MODE_DECR  = 2'd1,
    MODE_CONST = 2'd2,
    MODE_WALK  = 2'd3
  } mode_e;

  // Pattern source control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GAP   = 2'd1,
    ST_VALID = 2'd2,
    ST_DONE  = 2'd3
  } src_state_e;

  // Galois right-shift feedback mask for x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // An all-zero LFSR would lock up, so a zero seed is swapped for this value.
  localparam logic [15:0] LFSR_ZERO_SUB = 16'h0001;

  // One Galois step: shift right, fold the taps in when a one falls out.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  function automatic logic [15:0] lfsr_seed_fix(input logic [15:0] s);
    lfsr_seed_fix = (s == 16'h0000) ? LFSR_ZERO_SUB : s;
  endfunction

endpackage

// File: rtl/stream_lfsr.sv
// 16-bit Galois LFSR with seed load and step enable, for throttling valid/ready.
// Latency: value_o is combinational (seed when loading), state registers on the clock edge.
// Backpressure: none; the owner steps it only when a random draw is consumed.
//
// Ports:
//  clk, rst   clock and synchronous active-high reset (state returns to 16'h0001)
//  load_i     replace the state with seed_i (zero seed substituted)
//  en_i       advance one step; with load_i the loaded seed is stepped in the same cycle
//  seed_i     seed value
//  value_o    value a draw should use this cycle (the seed when loading)
//  state_o    registered LFSR state
module stream_lfsr
  import stream_utils_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        en_i,
  input  logic [15:0] seed_i,
  output logic [15:0] value_o,
  output logic [15:0] state_o
);

  logic [15:0] state_q;
  logic [15:0] state_d;
  logic [15:0] cur_val;

  // A load makes the new seed the current value immediately, so the very
  // cycle that loads can also make a draw and step past it.
  always_comb begin
    cur_val = load_i ? lfsr_seed_fix(seed_i) : state_q;
    state_d = en_i ? lfsr_step(cur_val) : cur_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LFSR_ZERO_SUB;
    end else begin
      state_q <= state_d;
    end
  end

  assign value_o = cur_val;
  assign state_o = state_q;

endmodule

// File: rtl/stream_pattern_source.sv
// Run-time configurable block generator on a valid/ready master port with LFSR-throttled valid.
// Latency: start_i at cycle N gives the first valid at N+1 when the throttle draw passes (always at full rate).
// Backpressure: a presented beat holds data/valid/last unchanged until stream_m_ready_i; no retraction.
//
// Ports:
//  clk, rst           clock and synchronous active-high reset
//  start_i            begin a block; mode/base/length/rate/seed sampled when idle
//  mode_i             0 incr, 1 decr, 2 constant, 3 walking-one
//  base_i             first data word for modes 0-2
//  length_i           beats in the block; 0 gives an empty block (done only)
//  rate_i             valid probability in 2^-RATE_W steps; all-ones = every cycle
//  seed_i             throttle LFSR seed (0 replaced by 16'h0001)
//  busy_o             block in progress (GAP or VALID)
//  done_o             one-cycle pulse after the final handshake
//  stream_m_*         master stream: data, valid, last out; ready in
module stream_pattern_source
  import stream_utils_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int LEN_W  = 16,
  parameter int RATE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [WIDTH-1:0]  base_i,
  input  logic [LEN_W-1:0]  length_i,
  input  logic [RATE_W-1:0] rate_i,
  input  logic [15:0]       seed_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [WIDTH-1:0]  stream_m_data_o,
  output logic              stream_m_valid_o,
  output logic              stream_m_last_o,
  input  logic              stream_m_ready_i
);

  // Low RATE_W bits of the LFSR are compared against the rate.
  localparam logic [15:0] RATE_MASK = 16'({RATE_W{1'b1}});

  src_state_e        state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d;

  logic              lfsr_load;
  logic              lfsr_en;
  logic [15:0]       lfsr_val;
  logic [15:0]       lfsr_state;

  logic [RATE_W-1:0] draw_rate;
  logic              draw_emit;
  logic              last_beat;
  logic [WIDTH-1:0]  first_word;

  // Data is generated incrementally from the word just sent, which keeps
  // walking-one free of any modulo-WIDTH arithmetic on the beat index.
  function automatic logic [WIDTH-1:0] next_word(input mode_e m, input logic [WIDTH-1:0] w);
    case (m)
      MODE_INCR: next_word = w + WIDTH'(1);
      MODE_DECR: next_word = w - WIDTH'(1);
      MODE_WALK: next_word = (w << 1) | (w >> (WIDTH - 1));
      default:   next_word = w;
    endcase
  endfunction

  stream_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (lfsr_load),
    .en_i    (lfsr_en),
    .seed_i  (seed_i),
    .value_o (lfsr_val),
    .state_o (lfsr_state)
  );

  always_comb begin
    // The start cycle already counts as the first throttle draw, using the
    // freshly loaded seed and the rate on the inputs; this is what gives
    // first valid at N+1 at full rate.
    draw_rate  = (state_q == ST_IDLE) ? rate_i : rate_q;
    draw_emit  = (&draw_rate) || ((lfsr_val & RATE_MASK) < 16'(draw_rate));
    last_beat  = (cnt_q == (len_q - LEN_W'(1)));
    first_word = (mode_e'(mode_i) == MODE_WALK) ? WIDTH'(1) : base_i;
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    rate_d    = rate_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mode_d    = mode_e'(mode_i);
          rate_d    = rate_i;
          len_d     = length_i;
          cnt_d     = '0;
          data_d    = first_word;
          lfsr_load = 1'b1;
          if (length_i == '0) begin
            state_d = ST_DONE;
          end else begin
            lfsr_en = 1'b1;
            if (draw_emit) begin
              valid_d = 1'b1;
              state_d = ST_VALID;
            end else begin
              state_d = ST_GAP;
            end
          end
        end
      end

      ST_GAP: begin
        // Every GAP cycle consumes one draw, pass or fail, so the valid
        // pattern depends only on seed and rate, never on the sink.
        lfsr_en = 1'b1;
        if (draw_emit) begin
          valid_d = 1'b1;
          state_d = ST_VALID;
        end
      end

      ST_VALID: begin
        if (stream_m_ready_i) begin
          cnt_d  = cnt_q + LEN_W'(1);
          data_d = next_word(mode_q, data_q);
          if (last_beat) begin
            valid_d = 1'b0;
            state_d = ST_DONE;
          end else if (!(&rate_q)) begin
            valid_d = 1'b0;
            state_d = ST_GAP;
          end
          // Full rate: stay in VALID with the next word, one beat per cycle.
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_INCR;
      rate_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rate_q  <= rate_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // last follows the beat counter, which cannot move while a beat waits
  // for ready, so it is as stable as data.
  assign stream_m_data_o  = data_q;
  assign stream_m_valid_o = valid_q;
  assign stream_m_last_o  = valid_q & last_beat;
  assign busy_o           = (state_q == ST_GAP) || (state_q == ST_VALID);
  assign done_o           = (state_q == ST_DONE);

endmodule

// File: tb/tb_stream_pattern_source.sv
module tb_stream_pattern_source;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] base;
  logic [15:0] length;
  logic [7:0]  rate;
  logic [15:0] seed;
  logic        ready;

  logic        busy, done, valid, last;
  logic [31:0] data;
  logic        busy8, done8, valid8, last8;
  logic [7:0]  data8;

  int checks = 0;
  int errors = 0;

  // Per-cycle trace of one block, index 0 = cycle after the start cycle.
  logic        tr_v[$];
  logic        tr_v8[$];
  logic        tr_l[$];
  logic        tr_done[$];
  logic        tr_busy[$];
  logic        tr_rdy[$];
  logic [31:0] tr_d[$];
  logic [7:0]  tr_d8[$];
  logic        timed_out;

  // Scoreboard queues, filled when a block is launched.
  logic [31:0] exp_d[$];
  logic [7:0]  exp_d8[$];
  logic        exp_l[$];
  int          exp_gap[$];

  always #5 clk = ~clk;

  stream_pattern_source #(.WIDTH(32), .LEN_W(16), .RATE_W(8)) dut (
    .clk(clk), .rst(rst), .start_i(start), .mode_i(mode), .base_i(base),
    .length_i(length), .rate_i(rate), .seed_i(seed), .busy_o(busy), .done_o(done),
    .stream_m_data_o(data), .stream_m_valid_o(valid), .stream_m_last_o(last),
    .stream_m_ready_i(ready)
  );

  stream_pattern_source #(.WIDTH(8), .LEN_W(16), .RATE_W(8)) dut8 (
    .clk(clk), .rst(rst), .start_i(start), .mode_i(mode), .base_i(base[7:0]),
    .length_i(length), .rate_i(rate), .seed_i(seed), .busy_o(busy8), .done_o(done8),
    .stream_m_data_o(data8), .stream_m_valid_o(valid8), .stream_m_last_o(last8),
    .stream_m_ready_i(ready)
  );

  // Launch one block and record the outputs until done (or max_cyc).
  // rk: 0 ready always, 1 ready low for the first 3 cycles of beat 1, 2 pseudo-random.
  // poke_at: trace index at which a conflicting start is pulsed (-1 none).
  task automatic run_block(input logic [1:0] m, input logic [31:0] b, input logic [15:0] len,
                           input logic [7:0] r, input logic [15:0] s, input int rk,
                           input int poke_at, input int max_cyc);
    int beats, hold;
    logic [31:0] xs;
    logic rdy;
    tr_v.delete(); tr_v8.delete(); tr_l.delete(); tr_done.delete();
    tr_busy.delete(); tr_rdy.delete(); tr_d.delete(); tr_d8.delete();
    timed_out = 1'b1;
    beats = 0; hold = 0; xs = 32'h2545_F491;
    @(negedge clk);
    mode = m; base = b; length = len; rate = r; seed = s; start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (i == poke_at) begin
        start = 1'b1; mode = 2'd2; base = 32'hDEAD_BEEF; length = 16'd3;
      end else if (i == poke_at + 1) begin
        start = 1'b0; mode = m; base = b; length = len;
      end
      case (rk)
        0: rdy = 1'b1;
        1: rdy = !(beats == 1 && hold < 3);
        default: begin
          xs ^= xs << 13; xs ^= xs >> 17; xs ^= xs << 5;
          rdy = xs[7];
        end
      endcase
      ready = rdy;
      tr_v.push_back(valid); tr_v8.push_back(valid8); tr_l.push_back(last);
      tr_done.push_back(done); tr_busy.push_back(busy); tr_rdy.push_back(rdy);
      tr_d.push_back(data); tr_d8.push_back(data8);
      if (valid === 1'b1 && rdy) begin beats++; hold = 0; end
      else if (valid === 1'b1) hold++;
      if (done === 1'b1) begin timed_out = 1'b0; break; end
      @(negedge clk);
    end
    start = 1'b0;
    ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 2'd0; base = '0; length = '0;
    rate = 8'hFF; seed = 16'h0001; ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", valid); end
    checks++; if (last !== 1'b0) begin errors++; $display("FAIL reset_last got %b expected 0", last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL reset_data got %h expected 0", data); end
    rst = 1'b0;
  endtask

  task automatic test_full_rate();
    logic [31:0] ed; logic el; int vcnt;
    exp_d.delete(); exp_l.delete();
    for (int k = 0; k < 4; k++) begin exp_d.push_back(32'h10 + k); exp_l.push_back(k == 3); end
    run_block(2'd0, 32'h10, 16'd4, 8'hFF, 16'h0001, 0, -1, 50);
    checks++;
    if (timed_out !== 1'b0 || tr_v.size() != 5) begin
      errors++; $display("FAIL full_done_cycle got index %0d timeout %b expected index 4", tr_v.size() - 1, timed_out);
    end
    vcnt = 0;
    foreach (tr_v[i]) if (tr_v[i] === 1'b1) vcnt++;
    checks++;
    if (vcnt != 4 || tr_v[0] !== 1'b1 || tr_v[3] !== 1'b1) begin
      errors++; $display("FAIL full_valid_cycles got %0d valid (first %b) expected 4 from cycle N+1", vcnt, tr_v[0]);
    end
    checks++; if (tr_busy[0] !== 1'b1) begin errors++; $display("FAIL full_busy got %b expected 1", tr_busy[0]); end
    foreach (tr_v[i]) if (tr_v[i] === 1'b1 && tr_rdy[i]) begin
      checks++;
      if (exp_d.size() == 0) begin errors++; $display("FAIL full_extra_beat data %h expected none", tr_d[i]); end
      else begin
        ed = exp_d.pop_front(); el = exp_l.pop_front();
        if (tr_d[i] !== ed || tr_l[i] !== el) begin
          errors++; $display("FAIL full_beat got %h last %b expected %h last %b", tr_d[i], tr_l[i], ed, el);
        end
      end
    end
    checks++; if (exp_d.size() != 0) begin errors++; $display("FAIL full_missing got %0d left expected 0", exp_d.size()); end
  endtask

  task automatic test_backpressure();
    logic [31:0] ed; logic el; int held;
    exp_d.delete(); exp_l.delete();
    for (int k = 0; k < 4; k++) begin exp_d.push_back(32'h10 + k); exp_l.push_back(k == 3); end
    run_block(2'd0, 32'h10, 16'd4, 8'hFF, 16'h0001, 1, -1, 50);
    held = 0;
    for (int i = 1; i <= 4 && i < tr_v.size(); i++)
      if (tr_v[i] === 1'b1 && tr_d[i] === 32'h11 && tr_l[i] === 1'b0) held++;
    checks++; if (held != 4) begin errors++; $display("FAIL bp_hold got %0d held cycles expected 4", held); end
    checks++;
    if (timed_out !== 1'b0 || tr_v.size() != 8) begin
      errors++; $display("FAIL bp_done_cycle got index %0d expected index 7", tr_v.size() - 1);
    end
    foreach (tr_v[i]) if (tr_v[i] === 1'b1 && tr_rdy[i]) begin
      checks++;
      if (exp_d.size() == 0) begin errors++; $display("FAIL bp_extra_beat data %h expected none", tr_d[i]); end
      else begin
        ed = exp_d.pop_front(); el = exp_l.pop_front();
        if (tr_d[i] !== ed || tr_l[i] !== el) begin
          errors++; $display("FAIL bp_beat got %h last %b expected %h last %b", tr_d[i], tr_l[i], ed, el);
        end
      end
    end
    checks++; if (exp_d.size() != 0) begin errors++; $display("FAIL bp_missing got %0d left expected 0", exp_d.size()); end
  endtask

  task automatic test_walk();
    logic [31:0] ed; logic [7:0] ed8; logic el; int bad, bad8, vmis;
    exp_d.delete(); exp_d8.delete(); exp_l.delete();
    for (int k = 0; k < 10; k++) begin
      ed = 32'h1 << k; ed8 = 8'h1 << (k % 8);
      exp_d.push_back(ed); exp_d8.push_back(ed8); exp_l.push_back(k == 9);
    end
    run_block(2'd3, 32'h5555_5555, 16'd10, 8'hFF, 16'h0001, 0, -1, 50);
    bad = 0; bad8 = 0; vmis = 0;
    foreach (tr_v[i]) begin
      if (tr_v8[i] !== tr_v[i]) vmis++;
      if (tr_v[i] === 1'b1 && tr_rdy[i]) begin
        if (exp_d.size() == 0) bad++;
        else begin
          ed = exp_d.pop_front(); ed8 = exp_d8.pop_front(); el = exp_l.pop_front();
          if (tr_d[i] !== ed || tr_l[i] !== el) bad++;
          if (tr_d8[i] !== ed8) begin
            bad8++; $display("FAIL walk8_beat got %h expected %h", tr_d8[i], ed8);
          end
        end
      end
    end
    checks++; if (bad != 0 || exp_d.size() != 0) begin errors++; $display("FAIL walk32 got %0d bad %0d left expected 0", bad, exp_d.size()); end
    checks++; if (bad8 != 0) errors++;
    checks++; if (vmis != 0) begin errors++; $display("FAIL walk8_valid got %0d differing cycles expected 0", vmis); end
  endtask

  task automatic test_decr_wrap_and_empty();
    logic [31:0] ed; logic [7:0] ed8; logic el; int bad;
    exp_d.delete(); exp_d8.delete(); exp_l.delete();
    exp_d.push_back(32'h1); exp_d.push_back(32'h0); exp_d.push_back(32'hFFFF_FFFF);
    exp_d8.push_back(8'h1); exp_d8.push_back(8'h0); exp_d8.push_back(8'hFF);
    exp_l.push_back(1'b0); exp_l.push_back(1'b0); exp_l.push_back(1'b1);
    run_block(2'd1, 32'h1, 16'd3, 8'hFF, 16'h0001, 0, -1, 50);
    bad = 0;
    foreach (tr_v[i]) if (tr_v[i] === 1'b1 && tr_rdy[i]) begin
      checks++;
      if (exp_d.size() == 0) begin errors++; $display("FAIL decr_extra_beat data %h expected none", tr_d[i]); end
      else begin
        ed = exp_d.pop_front(); ed8 = exp_d8.pop_front(); el = exp_l.pop_front();
        if (tr_d[i] !== ed || tr_d8[i] !== ed8 || tr_l[i] !== el) begin
          errors++; $display("FAIL decr_beat got %h/%h last %b expected %h/%h last %b", tr_d[i], tr_d8[i], tr_l[i], ed, ed8, el);
        end
      end
    end
    checks++; if (exp_d.size() != 0) begin errors++; $display("FAIL decr_missing got %0d left expected 0", exp_d.size()); end
    // Empty block: done one cycle after start, no valid, never busy.
    run_block(2'd0, 32'h77, 16'd0, 8'hFF, 16'h0001, 0, -1, 20);
    checks++;
    if (timed_out !== 1'b0 || tr_v.size() != 1 || tr_done[0] !== 1'b1) begin
      errors++; $display("FAIL empty_done got index %0d timeout %b expected done at index 0", tr_v.size() - 1, timed_out);
    end
    checks++;
    if (tr_v[0] !== 1'b0 || tr_busy[0] !== 1'b0) begin
      errors++; $display("FAIL empty_quiet got valid %b busy %b expected 0 0", tr_v[0], tr_busy[0]);
    end
  endtask

  task automatic test_throttle();
    logic [31:0] ed; logic el; logic [15:0] l; logic emit;
    logic saved_v[$];
    int d, bad, gap_bad, lowcnt, eg, vcnt, bcnt, diff;
    logic newbeat;
    for (int run = 0; run < 2; run++) begin
      exp_d.delete(); exp_l.delete(); exp_gap.delete();
      l = 16'hACE1;
      for (int k = 0; k < 1000; k++) begin
        exp_d.push_back(32'hA000_0000 + k); exp_l.push_back(k == 999);
        d = 0;
        do begin
          emit = (l[7:0] < 8'h80);
          l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
          d++;
        end while (!emit);
        exp_gap.push_back((k == 0) ? d - 1 : d);
      end
      run_block(2'd0, 32'hA000_0000, 16'd1000, 8'h80, 16'hACE1, 2, 10, 20000);
      bad = 0; gap_bad = 0; lowcnt = 0; newbeat = 1'b1; vcnt = 0; bcnt = 0;
      foreach (tr_v[i]) begin
        if (tr_busy[i] === 1'b1) bcnt++;
        if (tr_v[i] === 1'b1) vcnt++;
        if (tr_busy[i] === 1'b1 && tr_v[i] !== 1'b1) lowcnt++;
        if (tr_v[i] === 1'b1 && newbeat) begin
          eg = (exp_gap.size() != 0) ? exp_gap.pop_front() : -1;
          if (lowcnt != eg) gap_bad++;
          newbeat = 1'b0;
        end
        if (tr_v[i] === 1'b1 && tr_rdy[i]) begin
          if (exp_d.size() == 0) bad++;
          else begin
            ed = exp_d.pop_front(); el = exp_l.pop_front();
            if (tr_d[i] !== ed || tr_l[i] !== el) bad++;
          end
          newbeat = 1'b1; lowcnt = 0;
        end
      end
      checks++;
      if (timed_out !== 1'b0 || bad != 0 || exp_d.size() != 0) begin
        errors++; $display("FAIL thr_beats run %0d got %0d bad %0d left timeout %b expected 0 0 0", run, bad, exp_d.size(), timed_out);
      end
      checks++;
      if (gap_bad != 0) begin errors++; $display("FAIL thr_gaps run %0d got %0d wrong gaps expected 0", run, gap_bad); end
      checks++;
      if (vcnt * 100 < bcnt * 45 || vcnt * 100 > bcnt * 55) begin
        errors++; $display("FAIL thr_duty run %0d got %0d valid of %0d busy expected 45-55 percent", run, vcnt, bcnt);
      end
      if (run == 0) begin
        saved_v.delete();
        foreach (tr_v[i]) saved_v.push_back(tr_v[i]);
      end else begin
        diff = (saved_v.size() != tr_v.size()) ? 1 : 0;
        foreach (tr_v[i]) if (i < saved_v.size() && saved_v[i] !== tr_v[i]) diff++;
        checks++;
        if (diff != 0) begin errors++; $display("FAIL thr_repeat got %0d differences expected 0", diff); end
      end
    end
  endtask

  task automatic test_stall();
    int vcnt;
    run_block(2'd0, 32'h0, 16'd2, 8'h00, 16'h0001, 0, -1, 40);
    vcnt = 0;
    foreach (tr_v[i]) if (tr_v[i] !== 1'b0) vcnt++;
    checks++;
    if (timed_out !== 1'b1 || vcnt != 0 || tr_busy[tr_busy.size() - 1] !== 1'b1) begin
      errors++; $display("FAIL stall got timeout %b valid %0d busy %b expected 1 0 1", timed_out, vcnt, tr_busy[tr_busy.size() - 1]);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_recover busy got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ed; logic el;
    @(negedge clk);
    mode = 2'd0; base = 32'h40; length = 16'd5; rate = 8'hFF; seed = 16'h0001; start = 1'b1; ready = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b expected 1", valid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (valid !== 1'b0 || last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mid_reset got valid %b last %b busy %b done %b expected 0 0 0 0", valid, last, busy, done);
    end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_no_done got %b expected 0", done); end
    ready = 1'b1;
    exp_d.delete(); exp_l.delete();
    for (int k = 0; k < 3; k++) begin exp_d.push_back(32'h50 + k); exp_l.push_back(k == 2); end
    run_block(2'd0, 32'h50, 16'd3, 8'hFF, 16'h0001, 0, -1, 50);
    foreach (tr_v[i]) if (tr_v[i] === 1'b1 && tr_rdy[i]) begin
      checks++;
      if (exp_d.size() == 0) begin errors++; $display("FAIL mid_extra_beat data %h expected none", tr_d[i]); end
      else begin
        ed = exp_d.pop_front(); el = exp_l.pop_front();
        if (tr_d[i] !== ed || tr_l[i] !== el) begin
          errors++; $display("FAIL mid_beat got %h last %b expected %h last %b", tr_d[i], tr_l[i], ed, el);
        end
      end
    end
    checks++;
    if (exp_d.size() != 0 || timed_out !== 1'b0) begin
      errors++; $display("FAIL mid_restart got %0d left timeout %b expected 0 0", exp_d.size(), timed_out);
    end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_backpressure();
    test_walk();
    test_decr_wrap_and_empty();
    test_throttle();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
